// File: rtl/chunked_adder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : chunked_adder_if
// Description : Operand / result handshake bundle for chunked_adder.
//               master = operand source + result consumer, slave = adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface chunked_adder_if #(
  parameter int WIDTH = 8
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;

  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, S, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, S, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/chunked_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : chunked_adder
// Description : Multi-cycle WIDTH-bit adder/subtractor. Processes CHUNK bits
//               per clock, rippling the carry through a registered bit.
//               Subtraction is A + ~B + ~cin. Flags signed overflow.
//               WIDTH must be a multiple of CHUNK.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  chunked_adder_if.slave bus
);

  localparam int c_NCHUNK = WIDTH / CHUNK;
  localparam int c_CNT_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_in_ready;
  logic               w_out_valid;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;      // already inverted for subtract
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_ovf;

  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK:0]     w_sum;
  logic               w_last;
  logic               w_ovf;
  logic               w_accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode; handshakes depend on state only
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == c_CNT_W'(c_NCHUNK - 1));

  // Select the operand chunks addressed by the chunk counter
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < c_NCHUNK; k++) begin
      if (r_cnt == c_CNT_W'(k)) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  assign w_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};

  // Carry-in to the MSB differs from its carry-out exactly when both addend
  // MSBs agree and the sum MSB does not; this form also holds for CHUNK = 1.
  assign w_ovf = (w_a_chunk[CHUNK-1] == w_b_chunk[CHUNK-1]) &&
                 (w_sum[CHUNK-1] != w_a_chunk[CHUNK-1]);

  // Operand capture, per-chunk add with carry ripple, and result flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.A;
      r_b     <= bus.sub ? ~bus.B : bus.B;
      r_carry <= bus.cin ^ bus.sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_carry <= w_sum[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
      for (int k = 0; k < c_NCHUNK; k++) begin
        if (r_cnt == c_CNT_W'(k)) begin
          r_s[k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
        end
      end
      if (w_last) begin
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.S         = r_s;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire
